// File: rtl/i2s_pkg.sv
// Shared constants and sizing helpers for the stereo I2S transmitter.
// Output format is selected with I2S_LEFT_JUST_EN (defined: left-justified, else standard I2S).
package i2s_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } i2s_mode_e;

`ifdef I2S_LEFT_JUST_EN
  localparam i2s_mode_e TX_MODE = MODE_LJ;
`else
  localparam i2s_mode_e TX_MODE = MODE_I2S;
`endif

  // Bits in one L+R frame.
  function automatic int frame_bits(input int slot_w);
    return 2 * slot_w;
  endfunction

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_tx_stereo_if.sv
// Sample-pair handshake between the mixer path (master) and the I2S transmitter (slave).
interface i2s_tx_stereo_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] SMP_L;
  logic [DATA_W-1:0] SMP_R;
  logic              SMP_VALID;
  logic              SMP_READY;

  modport master (output SMP_L, output SMP_R, output SMP_VALID, input SMP_READY);
  modport slave  (input SMP_L, input SMP_R, input SMP_VALID, output SMP_READY);

endinterface

// File: rtl/i2s_clk_div.sv
// Bit/word clock generator: free-running SCK divider plus BCK/LCK derived from bck_cnt/bit_cnt.
// bit_tick marks the BCK falling edge, frame_tick the last bit of a frame (frame load).
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int SLOT_W  = 32,
  parameter int BCK_DIV = 4,
  parameter int SCK_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic SCK,
  output logic BCK,
  output logic LCK,
  output logic bit_tick,
  output logic frame_tick
);

  localparam int FRAME_BITS = frame_bits(SLOT_W);
  localparam int BCK_W      = cnt_w(BCK_DIV);
  localparam int BIT_W      = cnt_w(FRAME_BITS);
  localparam int SCK_W      = cnt_w(SCK_DIV);

  localparam logic [BCK_W-1:0] BCK_LAST = BCK_W'(BCK_DIV - 1);
  localparam logic [BCK_W-1:0] BCK_HALF = BCK_W'(BCK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SLOT_W);
  localparam logic [SCK_W-1:0] SCK_LAST = SCK_W'(SCK_DIV - 1);
  localparam logic [SCK_W-1:0] SCK_HALF = SCK_W'(SCK_DIV / 2);

  logic [BCK_W-1:0] bck_cnt_reg, bck_cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [SCK_W-1:0] sck_cnt_reg, sck_cnt_next;

  always_comb begin
    bit_tick     = (bck_cnt_reg == BCK_LAST);
    frame_tick   = bit_tick && (bit_cnt_reg == BIT_LAST);
    bck_cnt_next = bit_tick ? '0 : bck_cnt_reg + BCK_W'(1);
    bit_cnt_next = bit_cnt_reg;
    if (bit_tick) begin
      bit_cnt_next = frame_tick ? '0 : bit_cnt_reg + BIT_W'(1);
    end
    sck_cnt_next = (sck_cnt_reg == SCK_LAST) ? '0 : sck_cnt_reg + SCK_W'(1);
  end

  // Clock outputs are decoded from the next counter values so they stay registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bck_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      sck_cnt_reg <= '0;
      BCK         <= 1'b0;
      LCK         <= 1'b0;
      SCK         <= 1'b0;
    end else begin
      bck_cnt_reg <= bck_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      sck_cnt_reg <= sck_cnt_next;
      BCK         <= (bck_cnt_next >= BCK_HALF);
      LCK         <= (bit_cnt_next >= BIT_HALF);
      SCK         <= (sck_cnt_next >= SCK_HALF);
    end
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S transmitter: one-pair holding register, frame shift register, underrun flag.
// Define I2S_LEFT_JUST_EN for left-justified output instead of the 1-BCK-delayed I2S format.
module i2s_tx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 32,
  parameter int BCK_DIV = 4,
  parameter int SCK_DIV = 2
) (
  input  logic           CLK,
  input  logic           RST,
  i2s_tx_stereo_if.slave smp,
  output logic           UNDERRUN,
  output logic           SCK,
  output logic           BCK,
  output logic           LCK,
  output logic           DIN
);

  localparam int FRAME_BITS = frame_bits(SLOT_W);
  localparam int PAD_W      = SLOT_W - DATA_W;

  // Index 1 = left channel, 0 = right, matching slot order within the frame word.
  logic [DATA_W-1:0]     hold_reg [2];
  logic [DATA_W-1:0]     last_reg [2];
  logic [DATA_W-1:0]     load_smp [2];
  logic [FRAME_BITS-1:0] load_word;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  hold_full_reg, hold_full_next;
  logic                  ready_reg, underrun_reg;
  logic                  lj_bit_reg, dly_bit_reg;
  logic                  xfer;
  logic                  bit_tick, frame_tick;

  i2s_clk_div #(
    .SLOT_W  (SLOT_W),
    .BCK_DIV (BCK_DIV),
    .SCK_DIV (SCK_DIV)
  ) u_clk_div (
    .CLK        (CLK),
    .RST        (RST),
    .SCK        (SCK),
    .BCK        (BCK),
    .LCK        (LCK),
    .bit_tick   (bit_tick),
    .frame_tick (frame_tick)
  );

  assign xfer = smp.SMP_VALID && ready_reg;

  // A pending pair wins; otherwise the last pair is replayed.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign load_smp[gi] = hold_full_reg ? hold_reg[gi] : last_reg[gi];
    assign load_word[gi*SLOT_W +: SLOT_W] = SLOT_W'(load_smp[gi]) << PAD_W;
  end

  always_comb begin
    hold_full_next = hold_full_reg;
    if (frame_tick) begin
      hold_full_next = 1'b0;
    end
    if (xfer) begin
      hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_reg      <= '{default: '0};
      last_reg      <= '{default: '0};
      shift_reg     <= '0;
      hold_full_reg <= 1'b0;
      ready_reg     <= 1'b0;
      underrun_reg  <= 1'b0;
      lj_bit_reg    <= 1'b0;
      dly_bit_reg   <= 1'b0;
    end else begin
      hold_full_reg <= hold_full_next;
      ready_reg     <= !hold_full_next;
      underrun_reg  <= frame_tick && !hold_full_reg;
      // The delay flop always takes the previous left-justified bit, so the
      // I2S stream stays continuous across slot and frame boundaries.
      if (frame_tick) begin
        shift_reg   <= load_word << 1;
        lj_bit_reg  <= load_word[FRAME_BITS-1];
        dly_bit_reg <= lj_bit_reg;
        if (hold_full_reg) begin
          last_reg <= hold_reg;
        end
      end else if (bit_tick) begin
        shift_reg   <= shift_reg << 1;
        lj_bit_reg  <= shift_reg[FRAME_BITS-1];
        dly_bit_reg <= lj_bit_reg;
      end
      if (xfer) begin
        hold_reg[1] <= smp.SMP_L;
        hold_reg[0] <= smp.SMP_R;
      end
    end
  end

  assign smp.SMP_READY = ready_reg;
  assign UNDERRUN      = underrun_reg;
  assign DIN           = (TX_MODE == MODE_LJ) ? lj_bit_reg : dly_bit_reg;

endmodule
